// File: rtl/i2c_reg_access_arbiter.sv
// i2c_reg_access_arbiter
//   Shares one i2c_master among NUM_REQ register clients. Each request is a
//   single register write or read. A winner is picked in IDLE, its request
//   fields are latched, and the byte handshakes are then sequenced:
//     write: START, {dev,0}, reg, data, STOP
//     read : START, {dev,0}, reg, repeated START, {dev,1}, read byte + NACK, STOP
//
//   Build option: define I2C_ARB_FIXED_PRIORITY_EN for fixed priority, where
//   the lowest request index always wins. Without it (default) arbitration is
//   round robin: the search starts at a pointer and wraps from NUM_REQ-1 to 0.
//
// Ports
//   clk_in, reset_n        clock, asynchronous active-low reset
//   req/req_rw             per-requester request and direction (1 = read)
//   req_dev_addr           7 bits per requester, slice i = [7i+6:7i]
//   req_reg_addr/req_wdata 8 bits per requester, slice i = [8i+7:8i]
//   grant                  one-hot, high from acceptance through the done cycle
//   done                   1-cycle completion pulse to the granted requester
//   rdata, err             read byte and status, valid while done is high
//                          (err: 0 ok, 1 NACK, 2 start/arbitration error, 3 bus clear)
//   transfer_start, transfer_continues, mode, data_tx   registered, to i2c_master
//   transfer_ready, transaction_complete, nack, data_rx,
//   start_err, arbitration_err, bus_clear               from i2c_master

module i2c_reg_access_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic [1:0]           err,
  output logic                 transfer_start,
  output logic                 transfer_continues,
  output logic                 mode,
  output logic [7:0]           data_tx,
  input  logic                 transfer_ready,
  input  logic                 transaction_complete,
  input  logic                 nack,
  input  logic [7:0]           data_rx,
  input  logic                 start_err,
  input  logic                 arbitration_err,
  input  logic                 bus_clear
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_DATA_W, S_ADDR_R, S_DATA_R, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [NUM_REQ-1:0]   grant_d, done_d;
  logic [7:0]           rdata_d, data_tx_d;
  logic [1:0]           err_d;
  logic                 start_d, cont_d, mode_d;
  logic [6:0]           dev_q, dev_d;
  logic [7:0]           reg_q, reg_d, wdata_q, wdata_d;
  logic                 rw_q, rw_d;
  logic                 nack_flag, nack_flag_d;
  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic                 abort;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]        rr_ptr, rr_ptr_d;
  logic [IW-1:0]        gnt_idx, gnt_idx_d;
`endif

  // Winner search: the first set request bit, scanning upward from the
  // round-robin pointer (or from index 0 in fixed-priority builds).
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef I2C_ARB_FIXED_PRIORITY_EN
      cand = IW'(k);
`else
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign abort = start_err | arbitration_err | bus_clear;

  // Next-state and next-output logic. Every master-side output is a register
  // that only moves on a grant, a transaction_complete, or an abort, so the
  // master always sees a stable byte and control set while it works.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    done_d      = done;
    rdata_d     = rdata;
    err_d       = err;
    start_d     = transfer_start;
    cont_d      = transfer_continues;
    mode_d      = mode;
    data_tx_d   = data_tx;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    nack_flag_d = nack_flag;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
    rr_ptr_d    = rr_ptr;
    gnt_idx_d   = gnt_idx;
`endif

    case (state)
      S_IDLE: begin
        if (win_found) begin
          grant_d     = ONE_HOT0 << win_idx;
          dev_d       = req_dev_addr[int'(win_idx)*7 +: 7];
          reg_d       = req_reg_addr[int'(win_idx)*8 +: 8];
          wdata_d     = req_wdata[int'(win_idx)*8 +: 8];
          rw_d        = req_rw[win_idx];
          nack_flag_d = 1'b0;
          start_d     = 1'b1;
          cont_d      = 1'b1;
          mode_d      = 1'b0;
          data_tx_d   = {req_dev_addr[int'(win_idx)*7 +: 7], 1'b0};
          state_d     = S_START;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
          gnt_idx_d   = win_idx;
`endif
        end
      end

      S_DONE: begin
        done_d    = '0;
        err_d     = 2'd0;
        grant_d   = '0;
        start_d   = 1'b0;
        cont_d    = 1'b0;
        mode_d    = 1'b0;
        data_tx_d = 8'h00;
        state_d   = S_IDLE;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
        rr_ptr_d  = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
`endif
      end

      default: begin
        if (abort) begin
          // Lost arbitration / start error outranks bus clear.
          state_d   = S_DONE;
          done_d    = grant;
          err_d     = (start_err || arbitration_err) ? 2'd2 : 2'd3;
          start_d   = 1'b0;
          cont_d    = 1'b0;
          mode_d    = 1'b0;
          data_tx_d = 8'h00;
        end else begin
          // A NACK on any byte we transmitted is remembered; the master has
          // already latched 'continue', so the sequence still runs to STOP.
          if (nack && (state == S_ADDR || state == S_REG ||
                       state == S_DATA_W || state == S_ADDR_R))
            nack_flag_d = 1'b1;

          case (state)
            S_START: begin
              if (transfer_ready && transfer_start)
                state_d = S_ADDR;
            end
            S_ADDR: begin
              if (transaction_complete) begin
                start_d   = 1'b0;
                mode_d    = 1'b0;
                cont_d    = !rw_q;
                data_tx_d = reg_q;
                state_d   = S_REG;
              end
            end
            S_REG: begin
              if (transaction_complete) begin
                if (rw_q) begin
                  start_d   = 1'b1;
                  cont_d    = 1'b1;
                  mode_d    = 1'b0;
                  data_tx_d = {dev_q, 1'b1};
                  state_d   = S_ADDR_R;
                end else begin
                  start_d   = 1'b0;
                  cont_d    = 1'b0;
                  data_tx_d = wdata_q;
                  state_d   = S_DATA_W;
                end
              end
            end
            S_ADDR_R: begin
              if (transaction_complete) begin
                start_d   = 1'b0;
                cont_d    = 1'b0;
                mode_d    = 1'b1;
                data_tx_d = 8'hFF;
                state_d   = S_DATA_R;
              end
            end
            S_DATA_W: begin
              if (transaction_complete) begin
                done_d  = grant;
                err_d   = (nack_flag || nack) ? 2'd1 : 2'd0;
                state_d = S_DONE;
              end
            end
            S_DATA_R: begin
              // The master NACKs the final read byte on purpose; not an error.
              if (transaction_complete) begin
                rdata_d = data_rx;
                done_d  = grant;
                err_d   = nack_flag ? 2'd1 : 2'd0;
                state_d = S_DONE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      grant              <= '0;
      done               <= '0;
      rdata              <= 8'h00;
      err                <= 2'd0;
      transfer_start     <= 1'b0;
      transfer_continues <= 1'b0;
      mode               <= 1'b0;
      data_tx            <= 8'h00;
      dev_q              <= 7'h00;
      reg_q              <= 8'h00;
      wdata_q            <= 8'h00;
      rw_q               <= 1'b0;
      nack_flag          <= 1'b0;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
      rr_ptr             <= '0;
      gnt_idx            <= '0;
`endif
    end else begin
      state              <= state_d;
      grant              <= grant_d;
      done               <= done_d;
      rdata              <= rdata_d;
      err                <= err_d;
      transfer_start     <= start_d;
      transfer_continues <= cont_d;
      mode               <= mode_d;
      data_tx            <= data_tx_d;
      dev_q              <= dev_d;
      reg_q              <= reg_d;
      wdata_q            <= wdata_d;
      rw_q               <= rw_d;
      nack_flag          <= nack_flag_d;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
      rr_ptr             <= rr_ptr_d;
      gnt_idx            <= gnt_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_reg_access_arbiter.sv
// tb_i2c_reg_access_arbiter
//   Directed bench for i2c_reg_access_arbiter. The i2c_master side is played
//   by the bench itself: it answers transfer_start with transfer_ready and
//   pulses transaction_complete (with nack / data_rx) once per byte, checking
//   the byte and control lines the arbiter presents before each pulse.

module tb_i2c_reg_access_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req_rw;
  logic [27:0] req_dev_addr;
  logic [31:0] req_reg_addr, req_wdata;
  logic [3:0]  grant, done;
  logic [7:0]  rdata;
  logic [1:0]  err;
  logic        transfer_start, transfer_continues, mode;
  logic [7:0]  data_tx;
  logic        transfer_ready, transaction_complete, nack;
  logic [7:0]  data_rx;
  logic        start_err, arbitration_err, bus_clear;

  int checkCount = 0;
  int failCount  = 0;

  i2c_reg_access_arbiter #(.NUM_REQ(4)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .req(req), .req_rw(req_rw), .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata), .err(err),
    .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .mode(mode), .data_tx(data_tx),
    .transfer_ready(transfer_ready), .transaction_complete(transaction_complete),
    .nack(nack), .data_rx(data_rx), .start_err(start_err),
    .arbitration_err(arbitration_err), .bus_clear(bus_clear)
  );

  always #5 clk_in = ~clk_in;

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one requester's fields and raise its req bit.
  task automatic applyStimulus(input int idx, input logic rw, input logic [6:0] dev,
                               input logic [7:0] regA, input logic [7:0] wdata);
    req_rw[idx]              = rw;
    req_dev_addr[idx*7 +: 7] = dev;
    req_reg_addr[idx*8 +: 8] = regA;
    req_wdata[idx*8 +: 8]    = wdata;
    req[idx]                 = 1'b1;
  endtask

  task automatic waitGrant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (grant != 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Play the master through a whole transfer for requester expIdx.
  // dropMode 0: clear all req at done; 1: drop req right after grant;
  // 2: keep req held.
  task automatic runTransfer(input int expIdx, input logic rw, input logic [6:0] dev,
                             input logic [7:0] regA, input logic [7:0] wdata,
                             input int nackByte, input logic [7:0] rx,
                             input logic [1:0] expErr, input int dropMode,
                             input int readyDelay);
    logic [7:0] expBytes [4];
    logic [2:0] expCtl [4];
    int nBytes;
    bit got;
    if (rw) begin
      nBytes   = 4;
      expBytes = '{{dev, 1'b0}, regA, {dev, 1'b1}, 8'hFF};
      expCtl   = '{3'b110, 3'b000, 3'b110, 3'b001};
    end else begin
      nBytes   = 3;
      expBytes = '{{dev, 1'b0}, regA, wdata, 8'h00};
      expCtl   = '{3'b110, 3'b010, 3'b000, 3'b000};
    end
    waitGrant(got);
    checkOutput($sformatf("grant_req%0d", expIdx), 32'(grant), 32'(1) << expIdx);
    if (!got) return;
    if (dropMode == 1) req[expIdx] = 1'b0;
    for (int w = 0; w < readyDelay; w++) begin
      @(negedge clk_in);
      checkOutput("start_held_while_busy", 32'({transfer_start, data_tx}),
                  32'({1'b1, dev, 1'b0}));
    end
    transfer_ready = 1'b1;
    @(negedge clk_in);
    for (int b = 0; b < nBytes; b++) begin
      checkOutput($sformatf("data_tx_byte%0d", b), 32'(data_tx), 32'(expBytes[b]));
      checkOutput($sformatf("start_cont_mode_byte%0d", b),
                  32'({transfer_start, transfer_continues, mode}), 32'(expCtl[b]));
      checkOutput($sformatf("no_early_done_byte%0d", b), 32'(done), 32'(0));
      transaction_complete = 1'b1;
      nack                 = (b == nackByte);
      data_rx              = (b == nBytes - 1) ? rx : 8'h00;
      @(negedge clk_in);
      transaction_complete = 1'b0;
      nack                 = 1'b0;
      data_rx              = 8'h00;
    end
    checkOutput("done_pulse", 32'(done), 32'(1) << expIdx);
    checkOutput("err_at_done", 32'(err), 32'(expErr));
    if (rw && expErr == 2'd0) checkOutput("rdata_at_done", 32'(rdata), 32'(rx));
    if (dropMode == 0) req = 4'b0000;
    @(negedge clk_in);
    checkOutput("done_cleared", 32'(done), 32'(0));
    checkOutput("grant_cleared", 32'(grant), 32'(0));
  endtask

  // Start a write, complete bytesBefore bytes, then inject master errors.
  task automatic abortTest(input int idx, input int bytesBefore, input logic se,
                           input logic ae, input logic bc, input logic [1:0] expErr);
    bit got;
    applyStimulus(idx, 1'b0, 7'h50, 8'h40, 8'h77);
    waitGrant(got);
    checkOutput("abort_grant", 32'(grant), 32'(1) << idx);
    if (!got) return;
    @(negedge clk_in);
    for (int b = 0; b < bytesBefore; b++) begin
      transaction_complete = 1'b1;
      @(negedge clk_in);
      transaction_complete = 1'b0;
    end
    start_err       = se;
    arbitration_err = ae;
    bus_clear       = bc;
    @(negedge clk_in);
    start_err       = 1'b0;
    arbitration_err = 1'b0;
    bus_clear       = 1'b0;
    checkOutput("abort_done", 32'(done), 32'(1) << idx);
    checkOutput("abort_err", 32'(err), 32'(expErr));
    req = 4'b0000;
    @(negedge clk_in);
    checkOutput("abort_idle_done_grant", 32'({done, grant}), 32'(0));
    checkOutput("abort_idle_master_side",
                32'({transfer_start, transfer_continues, mode, data_tx}), 32'(0));
  endtask

  initial begin
    int order [4];
`ifdef I2C_ARB_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 2, 0, 2};
`endif
    reset_n = 1'b0;
    req = '0; req_rw = '0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
    transfer_ready = 1'b1; transaction_complete = 1'b0; nack = 1'b0; data_rx = 8'h00;
    start_err = 1'b0; arbitration_err = 1'b0; bus_clear = 1'b0;
    #1;
    checkOutput("reset_grant_done", 32'({grant, done}), 32'(0));
    checkOutput("reset_err_rdata", 32'({err, rdata}), 32'(0));
    checkOutput("reset_master_side",
                32'({transfer_start, transfer_continues, mode, data_tx}), 32'(0));
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);

    $display("[TB] write to 0x50 reg 0x10, bus busy for two cycles first");
    transfer_ready = 1'b0;
    applyStimulus(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    runTransfer(0, 1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 2'd0, 0, 2);

    $display("[TB] read from 0x50 reg 0x20, req dropped right after grant");
    applyStimulus(1, 1'b1, 7'h50, 8'h20, 8'h00);
    runTransfer(1, 1'b1, 7'h50, 8'h20, 8'h00, 3, 8'h3C, 2'd0, 1, 0);

    $display("[TB] write to absent device 0x51");
    applyStimulus(3, 1'b0, 7'h51, 8'h10, 8'h5A);
    runTransfer(3, 1'b0, 7'h51, 8'h10, 8'h5A, 0, 8'h00, 2'd1, 0, 0);

    $display("[TB] nack on the data byte only");
    applyStimulus(3, 1'b0, 7'h50, 8'h11, 8'h66);
    runTransfer(3, 1'b0, 7'h50, 8'h11, 8'h66, 2, 8'h00, 2'd1, 0, 0);

    $display("[TB] requesters 0 and 2 held high together");
    applyStimulus(0, 1'b0, 7'h50, 8'h30, 8'h11);
    applyStimulus(2, 1'b0, 7'h50, 8'h32, 8'h22);
    for (int k = 0; k < 4; k++) begin
      runTransfer(order[k], 1'b0, 7'h50, (order[k] == 0) ? 8'h30 : 8'h32,
                  (order[k] == 0) ? 8'h11 : 8'h22, -1, 8'h00, 2'd0,
                  (k == 3) ? 0 : 2, 0);
    end

    $display("[TB] aborts: arbitration_err in REG, bus_clear in ADDR, both kinds in DATA_W");
    abortTest(1, 1, 1'b0, 1'b1, 1'b0, 2'd2);
    abortTest(1, 0, 1'b0, 1'b0, 1'b1, 2'd3);
    abortTest(1, 2, 1'b1, 1'b0, 1'b1, 2'd2);

    $display("[TB] reset during DATA_W");
    begin
      bit got;
      applyStimulus(2, 1'b0, 7'h50, 8'h60, 8'hC3);
      waitGrant(got);
      checkOutput("pre_reset_grant", 32'(grant), 32'(4));
      @(negedge clk_in);
      for (int b = 0; b < 2; b++) begin
        transaction_complete = 1'b1;
        @(negedge clk_in);
        transaction_complete = 1'b0;
      end
      checkOutput("pre_reset_data_tx", 32'(data_tx), 32'(8'hC3));
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midreset_grant_done", 32'({grant, done}), 32'(0));
      checkOutput("midreset_master_side",
                  32'({transfer_start, transfer_continues, mode, data_tx}), 32'(0));
      checkOutput("midreset_err_rdata", 32'({err, rdata}), 32'(0));
      @(negedge clk_in);
      reset_n = 1'b1;
      runTransfer(2, 1'b0, 7'h50, 8'h60, 8'hC3, -1, 8'h00, 2'd0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
